vending_machine_param: RTL and testbench

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vm_pkg.sv | 19 +
 rtl/vending_machine_param_if.sv | 31 +++
 rtl/vm_coin_decode.sv | 26 ++
 rtl/vending_machine_param.sv | 147 ++++++++++++++
 tb/tb_vending_machine_param.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared types and constants for the parameterised vending machine.
// No logic, so no latency.
// No flow control lives here.
package vm_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      PAYOUT  = 2'd3
   } vm_state_t;

   // Accepted coin denominations, as presented on coin_value
   localparam logic [2:0] COIN_1 = 3'd1;
   localparam logic [2:0] COIN_3 = 3'd3;
   localparam logic [2:0] COIN_5 = 3'd5;

endpackage

// File: rtl/vending_machine_param_if.sv
// Buyer/payout-side signal bundle of the vending machine.
// No logic, so no latency.
// Change payout is valid/ready: change_valid is held until change_ready.
interface vending_machine_param_if #(
   parameter int CREDIT_W = 4
);
   logic                coin_valid;
   logic [2:0]          coin_value;
   logic                cancel;
   logic                restock;
   logic                change_ready;
   logic                ship;
   logic                coin_reject;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                is_refund;
   logic [CREDIT_W-1:0] credit;
   logic                sold_out;

   // Machine side
   modport slave (
      input  coin_valid, coin_value, cancel, restock, change_ready,
      output ship, coin_reject, change_valid, change_amt, is_refund, credit, sold_out
   );

   // Buyer / payout mechanism side
   modport master (
      output coin_valid, coin_value, cancel, restock, change_ready,
      input  ship, coin_reject, change_valid, change_amt, is_refund, credit, sold_out
   );
endinterface

// File: rtl/vm_coin_decode.sv
// Coin decoder: flags legal denominations and maps them to credit units.
// Purely combinational, zero cycles.
// No flow control; illegal codes decode to amount 0.
module vm_coin_decode
   import vm_pkg::*;
#(
   parameter int CREDIT_W = 4
)(
   input  logic [2:0]          i_coin_value,
   output logic                o_legal,
   output logic [CREDIT_W-1:0] o_amount
);

   // Legality check and value mapping
   always_comb begin
      o_legal  = 1'b0;
      o_amount = '0;
      case (i_coin_value)
         COIN_1: begin o_legal = 1'b1; o_amount = CREDIT_W'(COIN_1); end
         COIN_3: begin o_legal = 1'b1; o_amount = CREDIT_W'(COIN_3); end
         COIN_5: begin o_legal = 1'b1; o_amount = CREDIT_W'(COIN_5); end
         default: begin o_legal = 1'b0; o_amount = '0; end
      endcase
   end

endmodule

// File: rtl/vending_machine_param.sv
// Single-item vending machine: collects coins, ships, pays change or refunds.
// All outputs registered; ship appears the cycle after the credit reaches PRICE.
// Change payout holds change_valid/amt/is_refund until change_ready; coins are rejected meanwhile.
module vending_machine_param
   import vm_pkg::*;
#(
   parameter int PRICE     = 7,
   parameter int STOCK_MAX = 15,
   parameter int CREDIT_W  = $clog2(PRICE + 5)
)(
   input  logic                  clk,
   input  logic                  rst,
   vending_machine_param_if.slave bus
);

   localparam int                  STOCK_W = $clog2(STOCK_MAX + 1);
   localparam logic [CREDIT_W-1:0] W_PRICE = CREDIT_W'(PRICE);

   vm_state_t           r_state, w_state_nxt;
   logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
   logic [STOCK_W-1:0]  r_stock, w_stock_nxt;
   logic                r_ship, w_ship_nxt;
   logic                r_reject, w_reject_nxt;
   logic                r_chg_vld, w_chg_vld_nxt;
   logic [CREDIT_W-1:0] r_chg_amt, w_chg_amt_nxt;
   logic                r_refund, w_refund_nxt;
   logic                r_sold_out, w_sold_out_nxt;

   logic                w_coin_legal;
   logic [CREDIT_W-1:0] w_coin_amt;
   logic [CREDIT_W-1:0] w_credit_sum;
   logic [CREDIT_W-1:0] w_change;
   logic                w_coin_ok;

   vm_coin_decode #(.CREDIT_W(CREDIT_W)) u_decode (
      .i_coin_value (bus.coin_value),
      .o_legal      (w_coin_legal),
      .o_amount     (w_coin_amt)
   );

   // A coin is only taken while collecting, in stock, and not being cancelled.
   // Credit stays below PRICE before a coin, so the sum is at most PRICE+4.
   assign w_coin_ok    = bus.coin_valid && w_coin_legal && !bus.cancel && !r_sold_out &&
                         ((r_state == IDLE) || (r_state == COLLECT));
   assign w_credit_sum = r_credit + w_coin_amt;
   assign w_change     = r_credit - W_PRICE;

   // Next-state and next-output computation for every register
   always_comb begin
      w_state_nxt   = r_state;
      w_credit_nxt  = r_credit;
      w_stock_nxt   = r_stock;
      w_ship_nxt    = 1'b0;
      w_reject_nxt  = bus.coin_valid && !w_coin_ok;
      w_chg_vld_nxt = r_chg_vld;
      w_chg_amt_nxt = r_chg_amt;
      w_refund_nxt  = r_refund;

      case (r_state)
         IDLE: begin
            w_credit_nxt = '0;
            if (w_coin_ok) begin
               w_credit_nxt = w_coin_amt;
               w_state_nxt  = (w_coin_amt >= W_PRICE) ? VEND : COLLECT;
            end
         end
         COLLECT: begin
            if (bus.cancel) begin
               w_state_nxt   = PAYOUT;
               w_chg_vld_nxt = 1'b1;
               w_chg_amt_nxt = r_credit;
               w_refund_nxt  = 1'b1;
               w_credit_nxt  = '0;
            end else if (w_coin_ok) begin
               w_credit_nxt = w_credit_sum;
               if (w_credit_sum >= W_PRICE) begin
                  w_state_nxt = VEND;
               end
            end
         end
         VEND: begin
            w_ship_nxt   = 1'b1;
            w_stock_nxt  = r_stock - STOCK_W'(1);
            w_credit_nxt = '0;
            if (w_change != '0) begin
               w_state_nxt   = PAYOUT;
               w_chg_vld_nxt = 1'b1;
               w_chg_amt_nxt = w_change;
               w_refund_nxt  = 1'b0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         PAYOUT: begin
            if (bus.change_ready) begin
               w_state_nxt   = IDLE;
               w_chg_vld_nxt = 1'b0;
               w_chg_amt_nxt = '0;
               w_refund_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Restock overrides a same-cycle sale decrement
      if (bus.restock) begin
         w_stock_nxt = STOCK_W'(STOCK_MAX);
      end
      w_sold_out_nxt = (w_stock_nxt == '0);
   end

   // State and registered outputs; reset clears a pending sale or payout at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_credit   <= '0;
         r_stock    <= STOCK_W'(STOCK_MAX);
         r_ship     <= 1'b0;
         r_reject   <= 1'b0;
         r_chg_vld  <= 1'b0;
         r_chg_amt  <= '0;
         r_refund   <= 1'b0;
         r_sold_out <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_credit   <= w_credit_nxt;
         r_stock    <= w_stock_nxt;
         r_ship     <= w_ship_nxt;
         r_reject   <= w_reject_nxt;
         r_chg_vld  <= w_chg_vld_nxt;
         r_chg_amt  <= w_chg_amt_nxt;
         r_refund   <= w_refund_nxt;
         r_sold_out <= w_sold_out_nxt;
      end
   end

   assign bus.ship         = r_ship;
   assign bus.coin_reject  = r_reject;
   assign bus.change_valid = r_chg_vld;
   assign bus.change_amt   = r_chg_amt;
   assign bus.is_refund    = r_refund;
   assign bus.credit       = r_credit;
   assign bus.sold_out     = r_sold_out;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for the vending machine: default build plus a one-item-stock build.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Expected output vectors are hand-computed per cycle.
module tb_vending_machine_param;
   import vm_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   logic [12:0] got;
   logic [12:0] exp;

   vending_machine_param_if #(.CREDIT_W(4)) ifa ();
   vending_machine_param_if #(.CREDIT_W(4)) ifb ();

   vending_machine_param #(.PRICE(7), .STOCK_MAX(15), .CREDIT_W(4)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   vending_machine_param #(.PRICE(7), .STOCK_MAX(1), .CREDIT_W(4)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required end before 200000");
      $fatal(1, "watchdog");
   end

   // Expected vector layout: ship, reject, change_valid, change_amt[4], is_refund, credit[4], sold_out
   function automatic logic [12:0] pk(input logic sh, input logic rj, input logic cv,
                                      input logic [3:0] amt, input logic rf,
                                      input logic [3:0] cr, input logic so);
      return {sh, rj, cv, amt, rf, cr, so};
   endfunction

   function automatic logic [12:0] obs_a();
      return {ifa.ship, ifa.coin_reject, ifa.change_valid, ifa.change_amt,
              ifa.is_refund, ifa.credit, ifa.sold_out};
   endfunction

   function automatic logic [12:0] obs_b();
      return {ifb.ship, ifb.coin_reject, ifb.change_valid, ifb.change_amt,
              ifb.is_refund, ifb.credit, ifb.sold_out};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic coin_a(input logic v, input logic [2:0] val);
      ifa.coin_valid = v;
      ifa.coin_value = val;
   endtask

   task automatic coin_b(input logic v, input logic [2:0] val);
      ifb.coin_valid = v;
      ifb.coin_value = val;
   endtask

   task automatic test_reset();
      #2;
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_a: got %b required %b", got, exp); end
      got = obs_b(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_b: got %b required %b", got, exp); end
      n_tests++;
      if (u_a.r_stock !== 4'd15 || u_a.r_state !== IDLE) begin
         n_fail++; $display("FAIL reset_stock_a: got stock %0d state %0d required 15 / IDLE", u_a.r_stock, u_a.r_state);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Coins 1,3,3 reach the price exactly: ship, no change
   task automatic test_exact_price();
      coin_a(1, 3'd1); step();
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd1,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL exact_c1: got %b required %b", got, exp); end
      coin_a(1, 3'd3); step();
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd4,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL exact_c3: got %b required %b", got, exp); end
      coin_a(1, 3'd3); step();
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd7,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL exact_c7: got %b required %b", got, exp); end
      coin_a(0, 3'd0); step();
      got = obs_a(); exp = pk(1,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL exact_ship: got %b required %b", got, exp); end
      n_tests++;
      if (u_a.r_stock !== 4'd14) begin n_fail++; $display("FAIL exact_stock: got %0d required 14", u_a.r_stock); end
      step();
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL exact_after: got %b required %b", got, exp); end
   endtask

   // Coins 5,5: change 3 held under backpressure, then accepted
   task automatic test_change_hold();
      coin_a(1, 3'd5); step();
      coin_a(1, 3'd5); step();
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd10,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL chg_c10: got %b required %b", got, exp); end
      coin_a(0, 3'd0); step();
      got = obs_a(); exp = pk(1,0,1,4'd3,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL chg_ship: got %b required %b", got, exp); end
      for (int i = 0; i < 4; i++) begin
         step();
         got = obs_a(); exp = pk(0,0,1,4'd3,0,4'd0,0); n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL chg_hold%0d: got %b required %b", i, got, exp); end
      end
      ifa.change_ready = 1'b1; step(); ifa.change_ready = 1'b0;
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL chg_done: got %b required %b", got, exp); end
      n_tests++;
      if (u_a.r_state !== IDLE || u_a.r_stock !== 4'd13) begin
         n_fail++; $display("FAIL chg_idle: got state %0d stock %0d required IDLE / 13", u_a.r_state, u_a.r_stock);
      end
   endtask

   // Cancel refunds the credit; cancel with a coin rejects the coin
   task automatic test_cancel();
      coin_a(1, 3'd5); step();
      coin_a(1, 3'd1); step();
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd6,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL cancel_c6: got %b required %b", got, exp); end
      coin_a(0, 3'd0); ifa.cancel = 1'b1; step(); ifa.cancel = 1'b0;
      got = obs_a(); exp = pk(0,0,1,4'd6,1,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL cancel_refund: got %b required %b", got, exp); end
      step();
      got = obs_a(); exp = pk(0,0,1,4'd6,1,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL cancel_hold: got %b required %b", got, exp); end
      ifa.change_ready = 1'b1; step(); ifa.change_ready = 1'b0;
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL cancel_done: got %b required %b", got, exp); end
      coin_a(1, 3'd3); step();
      coin_a(1, 3'd5); ifa.cancel = 1'b1; step(); ifa.cancel = 1'b0; coin_a(0, 3'd0);
      got = obs_a(); exp = pk(0,1,1,4'd3,1,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL cancel_coin: got %b required %b", got, exp); end
      ifa.change_ready = 1'b1; step(); ifa.change_ready = 1'b0;
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL cancel_coin_done: got %b required %b", got, exp); end
   endtask

   // Illegal values and coins during VEND/PAYOUT are returned
   task automatic test_reject();
      coin_a(1, 3'd2); step();
      got = obs_a(); exp = pk(0,1,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rej_2: got %b required %b", got, exp); end
      coin_a(1, 3'd4); step();
      got = obs_a(); exp = pk(0,1,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rej_4: got %b required %b", got, exp); end
      coin_a(1, 3'd5); step();
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd5,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rej_c5: got %b required %b", got, exp); end
      coin_a(1, 3'd5); step();
      coin_a(1, 3'd1); step();
      got = obs_a(); exp = pk(1,1,1,4'd3,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rej_vend: got %b required %b", got, exp); end
      coin_a(1, 3'd1); step();
      got = obs_a(); exp = pk(0,1,1,4'd3,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rej_payout: got %b required %b", got, exp); end
      coin_a(0, 3'd0); ifa.change_ready = 1'b1; step(); ifa.change_ready = 1'b0;
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rej_done: got %b required %b", got, exp); end
   endtask

   // Asynchronous reset while change 4 is pending
   task automatic test_reset_payout();
      coin_a(1, 3'd5); step();
      coin_a(1, 3'd1); step();
      coin_a(1, 3'd5); step();
      coin_a(0, 3'd0); step();
      got = obs_a(); exp = pk(1,0,1,4'd4,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rstp_ship: got %b required %b", got, exp); end
      step();
      got = obs_a(); exp = pk(0,0,1,4'd4,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rstp_pending: got %b required %b", got, exp); end
      #2 rst = 1'b1;
      #1;
      got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rstp_immediate: got %b required %b", got, exp); end
      n_tests++;
      if (u_a.r_stock !== 4'd15 || u_a.r_state !== IDLE) begin
         n_fail++; $display("FAIL rstp_state: got stock %0d state %0d required 15 / IDLE", u_a.r_stock, u_a.r_state);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         got = obs_a(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL rstp_quiet%0d: got %b required %b", i, got, exp); end
      end
   endtask

   // One-item stock: sale, sold out, reject, restock, sale again
   task automatic test_sold_out_restock();
      coin_b(1, 3'd5); step();
      coin_b(1, 3'd3); step();
      coin_b(0, 3'd0); step();
      got = obs_b(); exp = pk(1,0,1,4'd1,0,4'd0,1); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL so_sale: got %b required %b", got, exp); end
      ifb.change_ready = 1'b1; step(); ifb.change_ready = 1'b0;
      got = obs_b(); exp = pk(0,0,0,4'd0,0,4'd0,1); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL so_paid: got %b required %b", got, exp); end
      coin_b(1, 3'd5); step();
      got = obs_b(); exp = pk(0,1,0,4'd0,0,4'd0,1); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL so_reject: got %b required %b", got, exp); end
      coin_b(0, 3'd0); ifb.restock = 1'b1; step(); ifb.restock = 1'b0;
      got = obs_b(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL so_restock: got %b required %b", got, exp); end
      coin_b(1, 3'd5); step();
      coin_b(1, 3'd1); step();
      coin_b(1, 3'd1); step();
      got = obs_b(); exp = pk(0,0,0,4'd0,0,4'd7,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL so_c7: got %b required %b", got, exp); end
      coin_b(0, 3'd0); step();
      got = obs_b(); exp = pk(1,0,0,4'd0,0,4'd0,1); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL so_sale2: got %b required %b", got, exp); end
   endtask

   // Restock in the VEND cycle beats the decrement
   task automatic test_restock_vs_vend();
      ifb.restock = 1'b1; step(); ifb.restock = 1'b0;
      coin_b(1, 3'd5); step();
      coin_b(1, 3'd3); step();
      coin_b(0, 3'd0); ifb.restock = 1'b1; step(); ifb.restock = 1'b0;
      got = obs_b(); exp = pk(1,0,1,4'd1,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rsv_ship: got %b required %b", got, exp); end
      n_tests++;
      if (u_b.r_stock !== 1'b1) begin n_fail++; $display("FAIL rsv_stock: got %0d required 1", u_b.r_stock); end
      ifb.change_ready = 1'b1; step(); ifb.change_ready = 1'b0;
      got = obs_b(); exp = pk(0,0,0,4'd0,0,4'd0,0); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rsv_done: got %b required %b", got, exp); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      coin_a(0, 3'd0);
      coin_b(0, 3'd0);
      ifa.cancel = 1'b0; ifa.restock = 1'b0; ifa.change_ready = 1'b0;
      ifb.cancel = 1'b0; ifb.restock = 1'b0; ifb.change_ready = 1'b0;
      test_reset();
      test_exact_price();
      test_change_hold();
      test_cancel();
      test_reject();
      test_reset_payout();
      test_sold_out_restock();
      test_restock_vs_vend();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
